booth_mult_seq: RTL

Sequential radix-4 Booth multiplier for the processor's multdiv path. It generalises the fixed 3-bit Booth recode into a parametrised iterative datapath that handles both signed and unsigned operands. It accepts operands with a start/ready handshake, retires 2 multiplier bits per cycle, and returns the full double-width product plus a single-width overflow flag for the ALU exception path.

---
 rtl/mult_pkg.sv | 20 ++
 rtl/booth_radix4_decode.sv | 32 +++
 rtl/booth_mult_seq.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/mult_pkg.sv
// Shared encodings for the sequential Booth multiplier: Booth op codes,
// multiple-select flag and controller states.
package mult_pkg;

  typedef enum logic [1:0] {
    PM_NONE = 2'b00,
    PM_SUB  = 2'b01,
    PM_ADD  = 2'b10
  } pm_e;

  localparam logic SHIFT_1M = 1'b0;
  localparam logic SHIFT_2M = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_e;

endpackage

// File: rtl/booth_radix4_decode.sv
// Radix-4 Booth recode of a 3-bit multiplier window into an add/sub op and
// a 1M/2M select.
module booth_radix4_decode
  import mult_pkg::*;
(
  input  logic [2:0] i_window,
  output pm_e        o_pm,
  output logic       o_shift
);

  always_comb begin
    o_pm    = PM_NONE;
    o_shift = SHIFT_1M;
    case (i_window)
      3'b001, 3'b010: o_pm = PM_ADD;
      3'b011: begin
        o_pm    = PM_ADD;
        o_shift = SHIFT_2M;
      end
      3'b100: begin
        o_pm    = PM_SUB;
        o_shift = SHIFT_2M;
      end
      3'b101, 3'b110: o_pm = PM_SUB;
      default: begin
        o_pm    = PM_NONE;
        o_shift = SHIFT_1M;
      end
    endcase
  end

endmodule

// File: rtl/booth_mult_seq.sv
// Iterative radix-4 Booth multiplier, signed or unsigned, two multiplier bits
// retired per cycle; full double-width product plus single-width overflow.
//
// state   | meaning
// IDLE    | waiting for start after reset
// RUN     | one Booth step per cycle, counter counts ITERS down to 1
// DONE    | product held; start accepted again
module booth_mult_seq
  import mult_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] multiplicand,
  input  logic [WIDTH-1:0] multiplier,
  output logic             busy,
  output logic             ready,
  output logic [WIDTH-1:0] result_lo,
  output logic [WIDTH-1:0] result_hi,
  output logic             overflow
);

  localparam int ITERS = (WIDTH + 2) / 2;
  localparam int E     = WIDTH + 2;
  localparam int CW    = $clog2(ITERS + 1);
  localparam logic [CW-1:0] CNT_INIT = CW'(ITERS);
  localparam logic [CW-1:0] CNT_LAST = CW'(1);

  state_e             r_state;
  state_e             w_state_nxt;
  logic [E-1:0]       r_m;
  logic [2*E:0]       r_p;
  logic [CW-1:0]      r_cnt;
  logic               r_signed;
  logic               r_fin;
  logic               r_ready;
  logic [WIDTH-1:0]   r_lo;
  logic [WIDTH-1:0]   r_hi;
  logic               r_ovf;

  logic               w_accept;
  logic [E-1:0]       w_a_ext;
  logic [E-1:0]       w_b_ext;
  pm_e                w_pm;
  logic               w_shift;
  logic [E:0]         w_op;
  logic [E:0]         w_acc;
  logic [E:0]         w_sum;
  logic [2*E:0]       w_p_step;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH:0]     w_top;
  logic               w_ovf;

  always_ff @(posedge clock) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (start) w_state_nxt = ST_RUN;
      ST_RUN:  if (r_cnt == CNT_LAST) w_state_nxt = ST_DONE;
      ST_DONE: if (start) w_state_nxt = ST_RUN;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign w_accept = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
  assign w_a_ext  = is_signed ? {{2{multiplicand[WIDTH-1]}}, multiplicand}
                              : {2'b00, multiplicand};
  assign w_b_ext  = is_signed ? {{2{multiplier[WIDTH-1]}}, multiplier}
                              : {2'b00, multiplier};

  booth_radix4_decode u_decode (
    .i_window (r_p[2:0]),
    .o_pm     (w_pm),
    .o_shift  (w_shift)
  );

  // One guard bit above the accumulator so +/-2M cannot wrap before the shift.
  assign w_op  = (w_shift == SHIFT_2M) ? {r_m, 1'b0} : {r_m[E-1], r_m};
  assign w_acc = {r_p[2*E], r_p[2*E:E+1]};

  always_comb begin
    w_sum = w_acc;
    case (w_pm)
      PM_ADD:  w_sum = w_acc + w_op;
      PM_SUB:  w_sum = w_acc - w_op;
      default: w_sum = w_acc;
    endcase
  end

  assign w_p_step = {w_sum[E], w_sum, r_p[E:2]};
  assign w_prod   = r_p[2*WIDTH:1];
  assign w_top    = w_prod[2*WIDTH-1:WIDTH-1];
  assign w_ovf    = r_signed ? ~((&w_top) | ~(|w_top))
                             : |w_prod[2*WIDTH-1:WIDTH];

  // r_fin marks the first DONE cycle; results and ready register one edge
  // later so a start held high restarts on that same edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_m      <= '0;
      r_p      <= '0;
      r_cnt    <= '0;
      r_signed <= 1'b0;
      r_fin    <= 1'b0;
      r_ready  <= 1'b0;
      r_lo     <= '0;
      r_hi     <= '0;
      r_ovf    <= 1'b0;
    end else begin
      r_fin   <= (r_state == ST_RUN) && (r_cnt == CNT_LAST);
      r_ready <= r_fin;
      if (r_fin) begin
        r_lo  <= w_prod[WIDTH-1:0];
        r_hi  <= w_prod[2*WIDTH-1:WIDTH];
        r_ovf <= w_ovf;
      end
      if (w_accept) begin
        r_m      <= w_a_ext;
        r_p      <= {{E{1'b0}}, w_b_ext, 1'b0};
        r_cnt    <= CNT_INIT;
        r_signed <= is_signed;
      end else if (r_state == ST_RUN) begin
        r_p   <= w_p_step;
        r_cnt <= r_cnt - 1'b1;
      end
    end
  end

  assign busy      = (r_state == ST_RUN);
  assign ready     = r_ready;
  assign result_lo = r_lo;
  assign result_hi = r_hi;
  assign overflow  = r_ovf;

endmodule
